// File: rtl/cpu_ctrl_pkg.sv
// Shared control types for the pipelined CPU front end.
// State encoding, register constants and hazard helpers.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    BR_FLUSH   = 2'd1,
    FETCH_WAIT = 2'd2
  } state_e;

  localparam logic [4:0]  REG_ZERO = 5'd0;
  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam int          WAIT_MAX = 255;

  // Load in EX writes a register the ID instruction reads
  function automatic logic load_use(
    input logic       memread,
    input logic [4:0] ex_rt,
    input logic [4:0] id_rs,
    input logic [4:0] id_rt,
    input logic       uses_rt
  );
    return memread && (ex_rt != REG_ZERO) &&
           ((ex_rt == id_rs) ||
            (uses_rt && (ex_rt == id_rt)));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  // Clear wins; otherwise count up until all ones
  always_ff @(posedge clk_i) begin
    if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/pc_hazard_sequencer.sv
// PC / IF-ID / ID-EX sequencing for load-use, branch and fetch wait.
// Mealy outputs; counters and error flag are registered.
module pc_hazard_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int BR_FLUSH_CYCLES = 1,
  parameter int WAIT_TIMEOUT    = 16,
  parameter int CNT_W           = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rt_i,
  input  logic             branch_taken_i,
  input  logic             imem_ready_i,
  output logic             pc_write_o,
  output logic             pc_sel_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             fetch_err_o
);

  localparam logic [1:0] BR_INIT  = 2'(BR_FLUSH_CYCLES - 1);
  localparam logic [7:0] WAIT_SAT = 8'(WAIT_MAX);
  localparam logic [7:0] WAIT_LIM = 8'(WAIT_TIMEOUT);

  state_e     state_q, state_d;
  logic [1:0] rem_q, rem_d;
  logic [7:0] wait_q, wait_d;
  logic       ret_br_q, ret_br_d;
  logic       err_q, err_d;

  logic hazard;
  logic do_br, do_wait, do_go;
  logic eff_br;

  assign hazard  = load_use(ex_memread_i, ex_rt_i,
                            id_rs_i, id_rt_i,
                            id_uses_rt_i);
  assign do_br   = branch_taken_i;
  assign do_wait = !branch_taken_i && !imem_ready_i;
  assign do_go   = !branch_taken_i && imem_ready_i;

  // Flush-state behaviour applies in BR_FLUSH or when resuming into it
  assign eff_br = (state_q == BR_FLUSH) ||
                  ((state_q == FETCH_WAIT) && ret_br_q);

  // State register; reset drops any pending flush or wait
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= RUN;
      rem_q    <= '0;
      wait_q   <= '0;
      ret_br_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      wait_q   <= wait_d;
      ret_br_q <= ret_br_d;
      err_q    <= err_d;
    end
  end

  // Next-state: redirect, fetch wait, or advance
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    wait_d   = wait_q;
    ret_br_d = ret_br_q;
    err_d    = err_q;
    unique case (1'b1)
      do_br: begin
        state_d  = (BR_INIT == 2'd0) ? RUN : BR_FLUSH;
        rem_d    = BR_INIT;
        wait_d   = '0;
        ret_br_d = 1'b0;
      end
      do_wait: begin
        state_d = FETCH_WAIT;
        if (state_q != FETCH_WAIT) begin
          wait_d   = 8'd1;
          ret_br_d = (state_q == BR_FLUSH);
        end else if (wait_q != WAIT_SAT) begin
          wait_d = wait_q + 8'd1;
        end
      end
      do_go: begin
        wait_d = '0;
        if (eff_br) begin
          rem_d   = rem_q - 2'd1;
          state_d = (rem_q == 2'd1) ? RUN : BR_FLUSH;
        end else begin
          state_d = RUN;
        end
      end
      default: ;
    endcase
    if (wait_d >= WAIT_LIM) begin
      err_d = 1'b1;
    end
  end

  // Control outputs from state and current hazards
  always_comb begin
    pc_write_o   = 1'b0;
    pc_sel_o     = 1'b0;
    ifid_write_o = 1'b0;
    ifid_flush_o = 1'b0;
    idex_flush_o = 1'b0;
    if (rst_i) begin
      ifid_flush_o = 1'b1;
      idex_flush_o = 1'b1;
    end else begin
      unique case (1'b1)
        do_br: begin
          pc_sel_o     = 1'b1;
          pc_write_o   = 1'b1;
          ifid_write_o = 1'b1;
          ifid_flush_o = 1'b1;
          idex_flush_o = 1'b1;
        end
        do_wait: begin
          ifid_write_o = 1'b1;
          ifid_flush_o = 1'b1;
        end
        do_go: begin
          if (eff_br) begin
            pc_write_o   = 1'b1;
            ifid_write_o = 1'b1;
            ifid_flush_o = 1'b1;
          end else if (hazard) begin
            idex_flush_o = 1'b1;
          end else begin
            pc_write_o   = 1'b1;
            ifid_write_o = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign fetch_err_o = err_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .clr   (rst_i),
    .inc   (!pc_write_o),
    .q     (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .clr   (rst_i),
    .inc   (do_br),
    .q     (flush_cnt_o)
  );

endmodule

// File: tb/tb_pc_hazard_sequencer.sv
// Bench for pc_hazard_sequencer against a cycle-level pipeline model.
// A second narrow-counter instance shares the stimulus.
module tb_pc_hazard_sequencer;

  localparam int BFC = 3;
  localparam int WT  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, uses_rt, memread, br, rdy;
  logic [4:0] rs, rt, ert;

  logic        a_pcw, a_sel, a_ifw, a_iff, a_idf, a_err;
  logic [15:0] a_stall, a_flush;
  logic        s_pcw, s_sel, s_ifw, s_iff, s_idf, s_err;
  logic [3:0]  s_stall, s_flush;

  pc_hazard_sequencer #(
    .BR_FLUSH_CYCLES(BFC), .WAIT_TIMEOUT(WT), .CNT_W(16)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .id_rs_i(rs), .id_rt_i(rt), .id_uses_rt_i(uses_rt),
    .ex_memread_i(memread), .ex_rt_i(ert),
    .branch_taken_i(br), .imem_ready_i(rdy),
    .pc_write_o(a_pcw), .pc_sel_o(a_sel),
    .ifid_write_o(a_ifw), .ifid_flush_o(a_iff),
    .idex_flush_o(a_idf),
    .stall_cnt_o(a_stall), .flush_cnt_o(a_flush),
    .fetch_err_o(a_err)
  );

  pc_hazard_sequencer #(
    .BR_FLUSH_CYCLES(BFC), .WAIT_TIMEOUT(WT), .CNT_W(4)
  ) dut_s (
    .clk_i(clk), .rst_i(rst),
    .id_rs_i(rs), .id_rt_i(rt), .id_uses_rt_i(uses_rt),
    .ex_memread_i(memread), .ex_rt_i(ert),
    .branch_taken_i(br), .imem_ready_i(rdy),
    .pc_write_o(s_pcw), .pc_sel_o(s_sel),
    .ifid_write_o(s_ifw), .ifid_flush_o(s_iff),
    .idex_flush_o(s_idf),
    .stall_cnt_o(s_stall), .flush_cnt_o(s_flush),
    .fetch_err_o(s_err)
  );

  wire [4:0] out_v = {a_pcw, a_sel, a_ifw, a_iff, a_idf};

  int total = 0;
  int bad   = 0;

  // model: bubbles still owed after a redirect, wait length, counts
  int   m_left, m_wait, m_stall, m_flush;
  bit   m_err;
  logic [4:0] exp_o;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic void model_eval();
    bit lu;
    lu = memread && (ert != 5'd0) &&
         (ert == rs || (uses_rt && ert == rt));
    if (rst)              exp_o = 5'b00011;
    else if (br)          exp_o = 5'b11111;
    else if (!rdy)        exp_o = 5'b00110;
    else if (m_left > 0)  exp_o = 5'b10110;
    else if (lu)          exp_o = 5'b00001;
    else                  exp_o = 5'b10100;
  endfunction

  function automatic void model_commit();
    if (rst) begin
      m_left = 0; m_wait = 0; m_err = 0;
      m_stall = 0; m_flush = 0;
    end else begin
      if (!exp_o[4]) m_stall++;
      if (br) begin
        m_flush++;
        m_left = BFC - 1;
        m_wait = 0;
      end else if (!rdy) begin
        m_wait = sat(m_wait + 1, 255);
        if (m_wait >= WT) m_err = 1;
      end else begin
        m_wait = 0;
        if (m_left > 0) m_left--;
      end
    end
  endfunction

  task automatic drive(input logic r, input logic b,
                       input logic ready, input logic mr,
                       input logic [4:0] e, input logic [4:0] s,
                       input logic [4:0] t, input logic ur);
    rst = r; br = b; rdy = ready; memread = mr;
    ert = e; rs = s; rt = t; uses_rt = ur;
    #1;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
  endtask

  task automatic do_reset();
    drive(1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    tick();
  endtask

  task automatic test_reset();
    drive(1, 1, 0, 1, 5'd3, 5'd3, 5'd3, 1);
    total++;
    if (out_v !== 5'b00011) begin
      bad++;
      $display("FAIL reset_out got=%b want=00011", out_v);
    end
    tick();
    total++;
    if (a_stall !== 16'd0 || a_flush !== 16'd0 || a_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_state stall=%0d flush=%0d err=%b want 0 0 0",
               a_stall, a_flush, a_err);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(0, 0, 1, 1, 5'd9, 5'd9, 5'd3, 0);
    total++;
    if (out_v !== 5'b00001) begin
      bad++;
      $display("FAIL lu_stall got=%b want=00001", out_v);
    end
    tick();
    drive(0, 0, 1, 0, 5'd9, 5'd9, 5'd3, 0);
    total++;
    if (out_v !== 5'b10100 || a_stall !== 16'd1) begin
      bad++;
      $display("FAIL lu_after got=%b stall=%0d want=10100 stall=1",
               out_v, a_stall);
    end
    tick();
    drive(0, 0, 1, 1, 5'd7, 5'd2, 5'd7, 1);
    total++;
    if (out_v !== 5'b00001) begin
      bad++;
      $display("FAIL lu_rt got=%b want=00001", out_v);
    end
    tick();
    drive(0, 0, 1, 1, 5'd7, 5'd2, 5'd7, 0);
    total++;
    if (out_v !== 5'b10100) begin
      bad++;
      $display("FAIL lu_rt_unused got=%b want=10100", out_v);
    end
    tick();
    total++;
    if (a_stall !== 16'(m_stall) || m_stall != 2) begin
      bad++;
      $display("FAIL lu_count got=%0d want=2", a_stall);
    end
  endtask

  task automatic test_zero_reg();
    do_reset();
    drive(0, 0, 1, 1, 5'd0, 5'd0, 5'd0, 1);
    total++;
    if (out_v !== 5'b10100) begin
      bad++;
      $display("FAIL zero_reg got=%b want=10100", out_v);
    end
    tick();
    total++;
    if (a_stall !== 16'd0) begin
      bad++;
      $display("FAIL zero_reg_cnt got=%0d want=0", a_stall);
    end
  endtask

  task automatic test_branch();
    logic [4:0] tbl [4];
    int sel_n, fl_n;
    tbl[0] = 5'b11111; tbl[1] = 5'b10110;
    tbl[2] = 5'b10110; tbl[3] = 5'b10100;
    sel_n = 0; fl_n = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (i == 0) drive(0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0);
      else if (i < 3) drive(0, 0, 1, 1, 5'd5, 5'd5, 5'd0, 0);
      else idle();
      sel_n += int'(a_sel);
      fl_n  += int'(a_iff);
      total++;
      if (out_v !== tbl[i]) begin
        bad++;
        $display("FAIL br_seq[%0d] got=%b want=%b", i, out_v, tbl[i]);
      end
      tick();
    end
    total++;
    if (sel_n != 1 || fl_n != 3 || a_flush !== 16'd1) begin
      bad++;
      $display("FAIL br_totals sel=%0d flush=%0d cnt=%0d want 1 3 1",
               sel_n, fl_n, a_flush);
    end
  endtask

  task automatic test_wait_in_flush();
    logic [4:0] tbl [6];
    tbl[0] = 5'b11111; tbl[1] = 5'b00110; tbl[2] = 5'b00110;
    tbl[3] = 5'b10110; tbl[4] = 5'b10110; tbl[5] = 5'b10100;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(0, i == 0, !(i == 1 || i == 2), 0,
            5'd0, 5'd0, 5'd0, 0);
      total++;
      if (out_v !== tbl[i] || out_v !== exp_o) begin
        bad++;
        $display("FAIL wait_flush[%0d] got=%b want=%b", i, out_v, tbl[i]);
      end
      tick();
    end
  endtask

  task automatic test_fetch_timeout();
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      total++;
      if (out_v !== 5'b00110) begin
        bad++;
        $display("FAIL wait_out[%0d] got=%b want=00110", k, out_v);
      end
      tick();
      total++;
      if (a_err !== logic'(k >= WT)) begin
        bad++;
        $display("FAIL wait_err[%0d] got=%b want=%b", k, a_err, k >= WT);
      end
    end
    total++;
    if (a_stall !== 16'd20) begin
      bad++;
      $display("FAIL wait_stall got=%0d want=20", a_stall);
    end
    idle();
    total++;
    if (out_v !== 5'b10100) begin
      bad++;
      $display("FAIL wait_resume got=%b want=10100", out_v);
    end
    tick();
    total++;
    if (a_err !== 1'b1) begin
      bad++;
      $display("FAIL wait_sticky got=%b want=1", a_err);
    end
  endtask

  task automatic test_br_loaduse();
    do_reset();
    drive(0, 1, 1, 1, 5'd4, 5'd4, 5'd0, 0);
    total++;
    if (out_v !== 5'b11111) begin
      bad++;
      $display("FAIL br_lu got=%b want=11111", out_v);
    end
    tick();
    total++;
    if (a_stall !== 16'd0 || a_flush !== 16'd1) begin
      bad++;
      $display("FAIL br_lu_cnt stall=%0d flush=%0d want 0 1",
               a_stall, a_flush);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    tick();
    do_reset();
    idle();
    total++;
    if (out_v !== 5'b10100 || a_flush !== 16'd0) begin
      bad++;
      $display("FAIL rst_flush got=%b cnt=%0d want=10100 0",
               out_v, a_flush);
    end
    for (int k = 0; k < 17; k++) begin
      drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      tick();
    end
    do_reset();
    idle();
    total++;
    if (out_v !== 5'b10100 || a_err !== 1'b0 || a_stall !== 16'd0) begin
      bad++;
      $display("FAIL rst_wait got=%b err=%b stall=%0d want=10100 0 0",
               out_v, a_err, a_stall);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 16; k++) begin
      drive(0, 0, 1, 1, 5'd6, 5'd6, 5'd0, 0);
      tick();
    end
    total++;
    if (s_stall !== 4'd15 || a_stall !== 16'd16) begin
      bad++;
      $display("FAIL sat_stall narrow=%0d wide=%0d want 15 16",
               s_stall, a_stall);
    end
  endtask

  task automatic test_random();
    logic r, b, rd, mr, ur;
    logic [4:0] e, s, t;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 59) == 0);
      b  = ($urandom_range(0, 9) == 0);
      rd = ($urandom_range(0, 4) != 0);
      mr = $urandom_range(0, 1) == 1;
      ur = $urandom_range(0, 1) == 1;
      e  = 5'($urandom_range(0, 3));
      s  = 5'($urandom_range(0, 3));
      t  = 5'($urandom_range(0, 3));
      drive(r, b, rd, mr, e, s, t, ur);
      total++;
      if (out_v !== exp_o) begin
        bad++;
        $display("FAIL rnd_out[%0d] got=%b want=%b", i, out_v, exp_o);
      end
      tick();
      total++;
      if (a_stall !== 16'(sat(m_stall, 65535)) ||
          a_flush !== 16'(sat(m_flush, 65535)) ||
          s_stall !== 4'(sat(m_stall, 15)) ||
          s_flush !== 4'(sat(m_flush, 15)) ||
          a_err !== logic'(m_err)) begin
        bad++;
        $display("FAIL rnd_cnt[%0d] got=%0d/%0d/%0d/%0d/%b want=%0d/%0d/%b",
                 i, a_stall, a_flush, s_stall, s_flush, a_err,
                 m_stall, m_flush, m_err);
      end
    end
  endtask

  initial begin
    m_left = 0; m_wait = 0; m_err = 0;
    m_stall = 0; m_flush = 0;
    test_reset();
    test_load_use();
    test_zero_reg();
    test_branch();
    test_wait_in_flush();
    test_fetch_timeout();
    test_br_loaduse();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
